exec_hazard_ctrl: RTL
=====================

Name: exec_hazard_ctrl

Overview:
- Pipeline interlock and forwarding controller for the 8-bit execution stage.
- Tracks the destination register, write-enable and load flag of the instructions now in EX and MEM.
- Drives operand-forwarding selects for the A/B inputs of the execution block.
- Inserts a one-cycle bubble on load-use hazards and flushes IF/ID after a taken branch.

Parameters:
- RW_W, 5, register-address width (matches RW_dec/RW_ex).
- FLUSH_CYCLES, 2, cycles flush stays asserted after a taken branch (legal 1..3).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- id_valid  in  1  ID stage holds a real instruction.
- rs_a_id  in  RW_W  source register feeding A.
- rs_b_id  in  RW_W  source register feeding B.
- use_a_id  in  1  instruction reads A.
- use_b_id  in  1  instruction reads B.
- rw_id  in  RW_W  destination register of the ID instruction.
- wr_en_id  in  1  ID instruction writes the register file.
- load_id  in  1  ID instruction is a memory load (mem_en=1, mem_rw=0, mem_mux_sel=1).
- branch_taken_ex  in  1  branch resolved taken in EX this cycle.
- fwd_a_sel  out  2  00 = register file, 01 = EX result (ans_ex), 10 = MEM/WB result.
- fwd_b_sel  out  2  same encoding for B.
- stall_pc  out  1  hold the PC.
- stall_id  out  1  hold the IF/ID register.
- bubble_ex  out  1  load a NOP into ID/EX (mem_en=0, write disabled).
- flush  out  1  squash IF/ID contents.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to RUN; EX and MEM scoreboard entries become invalid.
  - All outputs are 0 immediately.
  - Deassertion takes effect at the next rising clk edge.
- Scoreboard update, each clk edge:
  - MEM entry <= EX entry.
  - EX entry <= {rw_id, wr_en_id & id_valid, load_id} when no bubble is inserted this cycle; otherwise EX entry <= invalid.
- Register 0 is not special; it is tracked like any other register.
- Forwarding (combinational from scoreboard and ID inputs, zero latency). For each operand X in {A, B}:
  - 01 if use_X_id, EX valid and wr, not load, and EX rw == rs_X_id.
  - else 10 if use_X_id, MEM valid and wr, and MEM rw == rs_X_id.
  - else 00.
  - EX match wins over MEM match.
  - A load sitting in EX never produces 01.
- Load-use hazard: id_valid, EX entry valid with wr and load, and (use_a & match or use_b & match).
- FSM states: RUN, LU_STALL, FLUSH.
  - RUN, branch_taken_ex=1: go to FLUSH, counter = FLUSH_CYCLES-1. flush=1 and bubble_ex=1 in the same cycle.
  - RUN, else if load-use hazard: stall_pc=stall_id=bubble_ex=1 combinationally; go to LU_STALL.
  - LU_STALL: outputs 0 and always return to RUN next cycle. The load is now in MEM, so forwarding gives 10.
  - FLUSH: flush=1 and bubble_ex=1; decrement the counter; go to RUN when the counter reaches 0.
- Simultaneous events:
  - branch_taken_ex and load-use hazard together: branch wins, no stall is asserted.
  - branch_taken_ex while in FLUSH: counter reloads to FLUSH_CYCLES-1.
  - branch_taken_ex while in LU_STALL: go to FLUSH.
- id_valid=0: no hazard; forwarding selects are 00.
- Reset mid-stall or mid-flush: abort immediately and return to RUN with all outputs 0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds output ports stall_cnt [15:0] and flush_cnt [15:0].
  - Each increments on every clk edge where stall_pc or flush respectively is 1.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. reset=0 for 3 cycles with random inputs -> all outputs 0 and scoreboard empty; release -> fwd_a_sel=fwd_b_sel=00 with no hazards.
2. ADD writing rw=5'b00101, next instruction with rs_a_id=5'b00101 -> fwd_a_sel=01. One instruction later, rs_b_id=5'b00101 -> fwd_b_sel=10.
3. Load to rw=5'b01010, next instruction with rs_b_id=5'b01010 and use_b=1 -> one cycle of stall_pc=stall_id=bubble_ex=1. Next cycle: stalls 0, fwd_b_sel=10.
4. branch_taken_ex=1 for one cycle with FLUSH_CYCLES=2 -> flush=1 for exactly 2 cycles, then RUN. With load-use present in the same cycle -> stall_pc stays 0.
5. Assert reset=0 during the second flush cycle -> flush drops to 0 asynchronously. After release, a matching rs issues with fwd=00 because the scoreboard was cleared.
6. With HAZARD_PERF_CNT_EN defined, run scenarios 3 and 4 -> stall_cnt=1, flush_cnt=2.

Source files
------------

// File: rtl/exec_hazard_ctrl.sv
// Execution-stage interlock and forwarding controller: operand bypass selects,
// load-use bubble, and IF/ID flush after a taken branch.
// Optional `HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module exec_hazard_ctrl #(
  parameter int RW_W         = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RW_W-1:0] rs_a_id,
  input  logic [RW_W-1:0] rs_b_id,
  input  logic            use_a_id,
  input  logic            use_b_id,
  input  logic [RW_W-1:0] rw_id,
  input  logic            wr_en_id,
  input  logic            load_id,
  input  logic            branch_taken_ex,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic            stall_pc,
  output logic            stall_id,
  output logic            bubble_ex,
  output logic            flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
`endif
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_LU_STALL  = 2'd1;
  localparam logic [1:0] ST_FLUSH     = 2'd2;
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  logic [1:0]      r_state;
  logic [1:0]      r_cnt;
  logic            r_ex_vld;
  logic            r_ex_wr;
  logic            r_ex_ld;
  logic [RW_W-1:0] r_ex_rw;
  logic            r_mem_vld;
  logic            r_mem_wr;
  logic [RW_W-1:0] r_mem_rw;

  logic            w_ex_hit_a;
  logic            w_ex_hit_b;
  logic            w_mem_hit_a;
  logic            w_mem_hit_b;
  logic            w_load_use;
  logic [1:0]      w_fwd_a;
  logic [1:0]      w_fwd_b;
  logic            w_stall;
  logic            w_bubble;
  logic            w_flush;
  logic [1:0]      w_nxt_state;
  logic [1:0]      w_nxt_cnt;

  assign w_ex_hit_a  = id_valid & use_a_id & r_ex_vld & r_ex_wr & (r_ex_rw == rs_a_id);
  assign w_ex_hit_b  = id_valid & use_b_id & r_ex_vld & r_ex_wr & (r_ex_rw == rs_b_id);
  assign w_mem_hit_a = id_valid & use_a_id & r_mem_vld & r_mem_wr & (r_mem_rw == rs_a_id);
  assign w_mem_hit_b = id_valid & use_b_id & r_mem_vld & r_mem_wr & (r_mem_rw == rs_b_id);
  // A load in EX has no result yet, so its match becomes a stall instead of a bypass.
  assign w_load_use  = r_ex_ld & (w_ex_hit_a | w_ex_hit_b);

  // Operand bypass selection; the younger EX result takes priority over MEM/WB.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (w_ex_hit_a && !r_ex_ld) begin
      w_fwd_a = 2'b01;
    end else if (w_mem_hit_a) begin
      w_fwd_a = 2'b10;
    end else begin
      w_fwd_a = 2'b00;
    end
    if (w_ex_hit_b && !r_ex_ld) begin
      w_fwd_b = 2'b01;
    end else if (w_mem_hit_b) begin
      w_fwd_b = 2'b10;
    end else begin
      w_fwd_b = 2'b00;
    end
  end

  // Interlock FSM next-state and control outputs; a taken branch overrides any stall.
  always_comb begin
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      ST_RUN, ST_LU_STALL: begin
        if (branch_taken_ex) begin
          w_flush     = 1'b1;
          w_bubble    = 1'b1;
          w_nxt_cnt   = FLUSH_RELOAD;
          w_nxt_state = (FLUSH_RELOAD == 2'd0) ? ST_RUN : ST_FLUSH;
        end else if ((r_state == ST_RUN) && w_load_use) begin
          w_stall     = 1'b1;
          w_bubble    = 1'b1;
          w_nxt_state = ST_LU_STALL;
        end else begin
          w_nxt_state = ST_RUN;
        end
      end
      ST_FLUSH: begin
        w_flush  = 1'b1;
        w_bubble = 1'b1;
        if (branch_taken_ex) begin
          w_nxt_cnt   = FLUSH_RELOAD;
          w_nxt_state = (FLUSH_RELOAD == 2'd0) ? ST_RUN : ST_FLUSH;
        end else if (r_cnt <= 2'd1) begin
          w_nxt_cnt   = 2'd0;
          w_nxt_state = ST_RUN;
        end else begin
          w_nxt_cnt   = r_cnt - 2'd1;
          w_nxt_state = ST_FLUSH;
        end
      end
      default: begin
        w_nxt_cnt   = 2'd0;
        w_nxt_state = ST_RUN;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held, without waiting for a clock.
  assign fwd_a_sel = reset ? w_fwd_a : 2'b00;
  assign fwd_b_sel = reset ? w_fwd_b : 2'b00;
  assign stall_pc  = reset & w_stall;
  assign stall_id  = reset & w_stall;
  assign bubble_ex = reset & w_bubble;
  assign flush     = reset & w_flush;

  // FSM state and flush counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // EX/MEM destination scoreboard; a bubble enters EX as an invalid entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_vld  <= 1'b0;
      r_ex_wr   <= 1'b0;
      r_ex_ld   <= 1'b0;
      r_ex_rw   <= '0;
      r_mem_vld <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_mem_rw  <= '0;
    end else begin
      r_mem_vld <= r_ex_vld;
      r_mem_wr  <= r_ex_wr;
      r_mem_rw  <= r_ex_rw;
      if (w_bubble) begin
        r_ex_vld <= 1'b0;
        r_ex_wr  <= 1'b0;
        r_ex_ld  <= 1'b0;
        r_ex_rw  <= '0;
      end else begin
        r_ex_vld <= 1'b1;
        r_ex_wr  <= wr_en_id & id_valid;
        r_ex_ld  <= load_id;
        r_ex_rw  <= rw_id;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (stall_pc && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'h0001;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flush && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'h0001;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end
`endif

endmodule
